data_gen_stream: RTL and testbench

Parametrised stream data generator, the successor to the 8-bit sequential/random generator. It produces bursts of test data for the accelerator datapath over a valid/ready handshake. Four pattern modes are supported, with programmable seed, stride and burst length, plus continuous mode and abort. It drives accelerator input ports during bring-up and self-test.

---
 rtl/data_gen_stream.sv | 174 +++++++++++++++++
 tb/tb_data_gen_stream.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_gen_stream.sv
// data_gen_stream: stream test-data generator with a valid/ready output.
// Each accepted start produces a burst of burst_len beats (0 = run until
// stop) using one of four patterns: sequential, Galois LFSR, constant or
// alternating.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, stop           begin a burst (IDLE only) / abort the running burst
//   mode, seed, stride    pattern select and parameters, latched on start
//   burst_len             beats per burst, 0 = continuous
//   data_out, out_valid,
//   out_last, out_ready   output stream handshake
//   busy, done            status: RUN/DONE, one-cycle end-of-burst pulse
//   beat_count            beats accepted since the last start
module data_gen_stream #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       LEN_W     = 8,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(8'hB8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] stride,
    input  logic [LEN_W-1:0]  burst_len,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  beat_count
);

    localparam logic [1:0] MODE_SEQ  = 2'b00;
    localparam logic [1:0] MODE_LFSR = 2'b01;
    localparam logic [1:0] MODE_CONST = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [DATA_W-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  count_q, count_d;

    logic              xfer;
    logic [LEN_W-1:0]  count_inc;

    // Pattern step applied on every accepted beat.
    function automatic logic [DATA_W-1:0] next_value(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] d,
        input logic [DATA_W-1:0] sd,
        input logic [DATA_W-1:0] st
    );
        logic [DATA_W-1:0] r;
        case (m)
            MODE_SEQ:   r = d + st;
            MODE_LFSR:  r = (d >> 1) ^ (d[0] ? LFSR_POLY : '0);
            MODE_CONST: r = d;
            default:    r = (d == sd) ? ~sd : sd;
        endcase
        return r;
    endfunction

    assign xfer      = valid_q && out_ready;
    assign count_inc = count_q + LEN_W'(1);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            seed_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            seed_q   <= seed_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        seed_d   = seed_q;
        stride_d = stride_q;
        len_d    = len_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    mode_d   = mode;
                    seed_d   = seed;
                    stride_d = stride;
                    len_d    = burst_len;
                    count_d  = '0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    last_d   = (burst_len == LEN_W'(1));
                    // All-zero is the LFSR lock-up state, so substitute all-ones.
                    data_d   = (mode == MODE_LFSR && seed == '0) ? '1 : seed;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    count_d = count_inc;
                    data_d  = next_value(mode_q, data_q, seed_q, stride_q);
                    last_d  = (len_q != '0) && (count_inc == len_q - LEN_W'(1));
                end
                // A beat transferred alongside stop still counts above.
                if ((xfer && last_q) || stop) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign data_out   = data_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign beat_count = count_q;

endmodule

// File: tb/tb_data_gen_stream.sv
// Scoreboard bench for data_gen_stream: expected beats are queued from a
// reference model when a burst is started and popped as beats transfer.
module tb_data_gen_stream;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] stride;
    logic [7:0] burst_len;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [7:0] beat_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;

    // {last, count, data}
    logic [16:0] sb[$];

    data_gen_stream dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .seed       (seed),
        .stride     (stride),
        .burst_len  (burst_len),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue n expected beats for one burst.
    task automatic push_model(input logic [1:0] m, input logic [7:0] sd, input logic [7:0] st,
                              input logic [7:0] len, input int n);
        logic [7:0] d;
        logic       lst;
        d = (m == 2'b01 && sd == 8'h00) ? 8'hFF : sd;
        for (int i = 0; i < n; i++) begin
            lst = (len != 8'd0) && (i == int'(len) - 1);
            sb.push_back({lst, 8'(i), d});
            case (m)
                2'b00:   d = d + st;
                2'b01:   d = {1'b0, d[7:1]} ^ (d[0] ? 8'hB8 : 8'h00);
                2'b10:   d = d;
                default: d = (d == sd) ? ~sd : sd;
            endcase
        end
    endtask

    // Pulse start, then scramble the inputs to show they were latched.
    task automatic start_burst(input logic [1:0] m, input logic [7:0] sd, input logic [7:0] st,
                               input logic [7:0] len);
        @(posedge clk); #1;
        mode = m; seed = sd; stride = st; burst_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = ~m; seed = ~sd; stride = 8'h55; burst_len = len + 8'd5;
        check_eq("first_valid", {31'd0, out_valid}, 32'd1);
        check_eq("busy_run", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int exp_cnt, input bit chk_lat, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            stop = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_seen", {31'd0, done}, 32'd1);
        if (seen) begin
            check_eq("done_busy", {31'd0, busy}, 32'd1);
            check_eq("done_valid", {31'd0, out_valid}, 32'd0);
            check_eq("done_count", {24'd0, beat_count}, 32'(exp_cnt % 256));
            if (chk_lat) check_eq("done_latency", 32'(cyc - last_xfer_cyc), 32'd0);
            @(posedge clk); #2;
            check_eq("done_pulse", {31'd0, done}, 32'd0);
            check_eq("idle_busy", {31'd0, busy}, 32'd0);
            check_eq("idle_count", {24'd0, beat_count}, 32'(exp_cnt % 256));
        end
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Scoreboard monitor: a transfer is seen here, completes at the next edge.
    always @(negedge clk) begin
        logic [16:0] e;
        cyc++;
        if (!reset && out_valid && out_ready) begin
            last_xfer_cyc = cyc;
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("beat_data", {24'd0, data_out}, {24'd0, e[7:0]});
                check_eq("beat_count", {24'd0, beat_count}, {24'd0, e[15:8]});
                check_eq("beat_last", {31'd0, out_last}, {31'd0, e[16]});
                if (dut.mode_q == 2'b01) check_eq("lfsr_nonzero", {31'd0, data_out == 8'h00}, 32'd0);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; seed = 8'h00;
        stride = 8'h00; burst_len = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_data", {24'd0, data_out}, 32'd0);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_count", {24'd0, beat_count}, 32'd0);
        reset = 1'b0;

        // Sequential burst at full throughput.
        push_model(2'b00, 8'h10, 8'd3, 8'd4, 4);
        start_burst(2'b00, 8'h10, 8'd3, 8'd4);
        wait_done(4, 1'b1, 20);

        // Wrap with backpressure; a start mid-burst must be ignored.
        out_ready = 1'b0;
        push_model(2'b00, 8'hFE, 8'd1, 8'd3, 3);
        start_burst(2'b00, 8'hFE, 8'd1, 8'd3);
        for (int k = 0; k < 3; k++) begin
            check_eq("stall_data", {24'd0, data_out}, 32'hFE);
            check_eq("stall_count", {24'd0, beat_count}, 32'd0);
            check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
            start = (k == 0);
            if (k == 0) begin mode = 2'b10; seed = 8'h77; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        wait_done(3, 1'b1, 20);

        // Stop while idle has no effect.
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check_eq("idle_stop_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_stop_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("idle_stop_done", {31'd0, done}, 32'd0);

        // Continuous LFSR, stopped together with the 300th transfer.
        push_model(2'b01, 8'h00, 8'd0, 8'd0, 300);
        start_burst(2'b01, 8'h00, 8'd0, 8'd0);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() <= 1) break;
            @(posedge clk); #1;
        end
        check_eq("lfsr_reach", 32'(sb.size()), 32'd1);
        stop = 1'b1;
        wait_done(300, 1'b1, 5);

        // Alternating and constant patterns.
        push_model(2'b11, 8'hA5, 8'd0, 8'd4, 4);
        start_burst(2'b11, 8'hA5, 8'd0, 8'd4);
        wait_done(4, 1'b1, 20);
        push_model(2'b10, 8'h3C, 8'd0, 8'd2, 2);
        start_burst(2'b10, 8'h3C, 8'd0, 8'd2);
        wait_done(2, 1'b1, 20);

        // Reset after two beats discards the burst without a done pulse.
        push_model(2'b00, 8'h40, 8'd1, 8'd8, 2);
        start_burst(2'b00, 8'h40, 8'd1, 8'd8);
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_data", {24'd0, data_out}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_last", {31'd0, out_last}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        check_eq("mid_rst_count", {24'd0, beat_count}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_eq("post_rst_done", {31'd0, done}, 32'd0);
        end
        out_ready = 1'b1;
        push_model(2'b00, 8'h40, 8'd1, 8'd3, 3);
        start_burst(2'b00, 8'h40, 8'd1, 8'd3);
        wait_done(3, 1'b1, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
